// File: rtl/counter_seq_pkg.sv
// Shared types and constants for the counter sequencing controller.
// COUNTER_SEQ_PERIOD_CNT_EN enables the done-pulse counter in counter_seq_ctrl.
package counter_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } ctrl_state_e;

    localparam int PERIOD_CNT_W = 8;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [PERIOD_CNT_W-1:0] sat_inc(input logic [PERIOD_CNT_W-1:0] v);
        if (v == {PERIOD_CNT_W{1'b1}}) begin
            return v;
        end
        return v + 1'b1;
    endfunction

endpackage

// File: rtl/up_counter_core.sv
// WIDTH-bit synchronous up counter; clr takes priority over en.
// Synchronous active-low reset.
module up_counter_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (en) begin
            q_d = q_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/counter_seq_ctrl.sv
// Start/abort/hold sequencer around up_counter_core with one-shot or periodic reload.
// Define COUNTER_SEQ_PERIOD_CNT_EN to add the saturating period_cnt output.
module counter_seq_ctrl
    import counter_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             hold,
    input  logic             periodic,
    input  logic [WIDTH-1:0] term_val,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
`ifdef COUNTER_SEQ_PERIOD_CNT_EN
    ,
    output logic [PERIOD_CNT_W-1:0] period_cnt
`endif
);

    ctrl_state_e      state_q;
    ctrl_state_e      state_d;
    logic [WIDTH-1:0] term_q;
    logic [WIDTH-1:0] term_d;
    logic             periodic_q;
    logic             periodic_d;
    logic             done_q;
    logic             done_d;
    logic             cnt_en;
    logic             cnt_clr;
    logic [WIDTH-1:0] cnt;
    logic             start_ok;
    logic             at_term;

`ifdef COUNTER_SEQ_PERIOD_CNT_EN
    logic [PERIOD_CNT_W-1:0] period_cnt_q;
    logic [PERIOD_CNT_W-1:0] period_cnt_d;
`endif

    up_counter_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk(clk),
        .rst(rst),
        .en (cnt_en),
        .clr(cnt_clr),
        .q  (cnt)
    );

    assign start_ok = start && ((state_q == IDLE) || (state_q == DONE));
    assign at_term  = (cnt == term_q);

    always_comb begin
        state_d    = state_q;
        term_d     = term_q;
        periodic_d = periodic_q;
        done_d     = 1'b0;
        cnt_en     = 1'b0;
        cnt_clr    = 1'b0;
`ifdef COUNTER_SEQ_PERIOD_CNT_EN
        period_cnt_d = period_cnt_q;
`endif
        if (abort) begin
            state_d = IDLE;
            cnt_clr = 1'b1;
`ifdef COUNTER_SEQ_PERIOD_CNT_EN
            period_cnt_d = '0;
`endif
        end else if (start_ok) begin
            state_d    = RUN;
            term_d     = term_val;
            periodic_d = periodic;
            cnt_clr    = 1'b1;
`ifdef COUNTER_SEQ_PERIOD_CNT_EN
            period_cnt_d = '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_clr = 1'b1;
                end
                // Releasing hold behaves like a normal RUN edge, so each held edge delays by exactly one.
                RUN, PAUSE: begin
                    if (hold) begin
                        state_d = PAUSE;
                    end else begin
                        state_d = RUN;
                        if (at_term) begin
                            done_d = 1'b1;
`ifdef COUNTER_SEQ_PERIOD_CNT_EN
                            period_cnt_d = sat_inc(period_cnt_q);
`endif
                            if (periodic_q) begin
                                cnt_clr = 1'b1;
                            end else begin
                                state_d = DONE;
                            end
                        end else begin
                            cnt_en = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = DONE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            term_q     <= '0;
            periodic_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            term_q     <= term_d;
            periodic_q <= periodic_d;
            done_q     <= done_d;
        end
    end

`ifdef COUNTER_SEQ_PERIOD_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            period_cnt_q <= '0;
        end else begin
            period_cnt_q <= period_cnt_d;
        end
    end

    assign period_cnt = period_cnt_q;
`endif

    always_comb begin
        busy = (state_q == RUN) || (state_q == PAUSE);
    end

    assign count = cnt;
    assign done  = done_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Self-checking bench for counter_seq_ctrl: directed scenarios plus random traffic
// compared cycle by cycle against a behavioural model of the sequencing rules.
module tb_counter_seq_ctrl;

    localparam int W = 4;
    localparam int MAXV = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic         hold = 1'b0;
    logic         periodic = 1'b0;
    logic [W-1:0] term_val = '0;
    logic [W-1:0] count;
    logic         busy;
    logic         done;
`ifdef COUNTER_SEQ_PERIOD_CNT_EN
    logic [7:0]   period_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Model: "active" = a run was accepted and has not finished; "paused" = active but held;
    // "finished" = one-shot reached its terminal value.
    bit m_active, m_paused, m_finished, m_done, m_per;
    int m_count, m_term, m_pc;

    counter_seq_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .abort   (abort),
        .hold    (hold),
        .periodic(periodic),
        .term_val(term_val),
        .count   (count),
        .busy    (busy),
        .done    (done)
`ifdef COUNTER_SEQ_PERIOD_CNT_EN
        ,
        .period_cnt(period_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        if (!rst) begin
            m_active = 0; m_paused = 0; m_finished = 0; m_done = 0;
            m_per = 0; m_count = 0; m_term = 0; m_pc = 0;
        end else if (abort) begin
            m_active = 0; m_paused = 0; m_finished = 0; m_done = 0;
            m_count = 0; m_pc = 0;
        end else if (start && !m_active) begin
            m_active = 1; m_paused = 0; m_finished = 0; m_done = 0;
            m_term = int'(term_val); m_per = periodic; m_count = 0; m_pc = 0;
        end else if (!m_active) begin
            m_done  = 0;
            m_count = m_finished ? m_term : 0;
        end else if (hold) begin
            m_paused = 1;
            m_done   = 0;
        end else begin
            m_paused = 0;
            if (m_count == m_term) begin
                m_done = 1;
                m_pc   = (m_pc < 255) ? m_pc + 1 : 255;
                if (m_per) begin
                    m_count = 0;
                end else begin
                    m_active   = 0;
                    m_finished = 1;
                end
            end else begin
                m_count = m_count + 1;
                m_done  = 0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".count"}, 32'(count), 32'(m_count));
        chk({tag, ".busy"},  32'(busy),  32'(m_active));
        chk({tag, ".done"},  32'(done),  32'(m_done));
`ifdef COUNTER_SEQ_PERIOD_CNT_EN
        chk({tag, ".period_cnt"}, 32'(period_cnt), 32'(m_pc));
`endif
    endtask

    task automatic cyc(input string tag, input logic r, input logic s, input logic a,
                       input logic h, input logic p, input logic [W-1:0] tv);
        rst = r; start = s; abort = a; hold = h; periodic = p; term_val = tv;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic idle_cycles(input string tag, input int n);
        for (int i = 0; i < n; i++) cyc(tag, 1, 0, 0, 0, 0, '0);
    endtask

    initial begin
        // Reset held with start asserted
        for (int i = 0; i < 3; i++) cyc("reset", 0, 1, 0, 0, 1, 4'd7);
        chk("reset.literal_count", 32'(count), 0);

        // One-shot, T=5: done exactly 6 edges after start, count held at 5
        cyc("os5_start", 1, 1, 0, 0, 0, 4'd5);
        for (int i = 1; i <= 5; i++) begin
            cyc("os5_run", 1, 0, 0, 0, 1, 4'd9);
            chk("os5.literal_count", 32'(count), 32'(i));
        end
        cyc("os5_term", 1, 0, 0, 0, 0, 4'd0);
        chk("os5.literal_done", 32'(done), 1);
        chk("os5.literal_busy", 32'(busy), 0);
        idle_cycles("os5_done", 4);
        chk("os5.literal_hold", 32'(count), 5);

        // Periodic, T=3
        cyc("per3_start", 1, 1, 0, 0, 1, 4'd3);
        idle_cycles("per3_run", 14);
        cyc("per3_abort", 1, 0, 1, 0, 0, '0);

        // Hold at count 4 for 4 edges, T=9
        cyc("hold_start", 1, 1, 0, 0, 0, 4'd9);
        idle_cycles("hold_pre", 4);
        for (int i = 0; i < 4; i++) cyc("hold_on", 1, 0, 0, 1, 0, '0);
        chk("hold.literal_count", 32'(count), 4);
        idle_cycles("hold_post", 8);

        // Abort at count 6; start during RUN ignored
        cyc("ab_start", 1, 1, 0, 0, 0, 4'd12);
        idle_cycles("ab_run", 3);
        cyc("ab_restart_ignored", 1, 1, 0, 0, 1, 4'd1);
        idle_cycles("ab_run2", 2);
        cyc("ab_abort", 1, 0, 1, 0, 0, '0);
        chk("ab.literal_count", 32'(count), 0);
        idle_cycles("ab_idle", 3);

        // start+abort together
        cyc("sa_both", 1, 1, 1, 0, 0, 4'd4);
        idle_cycles("sa_idle", 2);

        // term_val=0 one-shot, then periodic
        cyc("t0_start", 1, 1, 0, 0, 0, 4'd0);
        idle_cycles("t0_os", 3);
        cyc("t0p_start", 1, 1, 0, 0, 1, 4'd0);
        idle_cycles("t0_per", 4);
        cyc("t0p_abort", 1, 0, 1, 0, 0, '0);

        // Full range periodic, then restart from DONE with a new value
        cyc("t15_start", 1, 1, 0, 0, 1, 4'(MAXV));
        idle_cycles("t15_run", 36);
        cyc("t15_abort", 1, 0, 1, 0, 0, '0);
        cyc("rs_start", 1, 1, 0, 0, 0, 4'd6);
        idle_cycles("rs_run", 9);
        cyc("rs_new", 1, 1, 0, 0, 0, 4'd2);
        idle_cycles("rs_run2", 5);

        // Reset mid-run
        cyc("rm_start", 1, 1, 0, 0, 1, 4'd8);
        idle_cycles("rm_run", 3);
        cyc("rm_reset", 0, 0, 0, 0, 0, '0);
        idle_cycles("rm_after", 2);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic r, s, a, h, p;
            logic [W-1:0] tv;
            r  = ($urandom_range(0, 99) >= 2);
            s  = ($urandom_range(0, 99) < 12);
            a  = ($urandom_range(0, 99) < 3);
            h  = ($urandom_range(0, 99) < 25);
            p  = 1'($urandom_range(0, 1));
            tv = (i % 5 == 0) ? 4'($urandom_range(0, 2)) : 4'($urandom_range(0, MAXV));
            cyc("rand", r, s, a, h, p, tv);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/counter_seq_ctrl.md
Name: counter_seq_ctrl

Overview:
- Sequencing controller for a WIDTH-bit up counter: start/abort/hold handshake, latched terminal value, one-shot or periodic mode, and a one-cycle done pulse at terminal count.
- Wraps a synchronous counter core and is the block that timers and event-driven logic use to run the counter datapath under control.
- Fully synchronous. Single clock domain.

Parameters:
- WIDTH, 4: counter and terminal-value width in bits.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-low reset (0 = reset).
- start  input  1  request a run; accepted only in IDLE or DONE.
- abort  input  1  return to IDLE from any state; highest priority.
- hold  input  1  level; pauses counting while high in RUN/PAUSE.
- periodic  input  1  mode; sampled with start (1 = auto-reload, 0 = one-shot).
- term_val  input  WIDTH  terminal count; sampled with start.
- count  output  WIDTH  current count value (registered).
- busy  output  1  high in RUN or PAUSE.
- done  output  1  one-cycle pulse when the terminal count is passed.

Behaviour:
- Reset (rst=0 at an edge): state IDLE, count=0, busy=0, done=0, latched term_q=0, latched periodic_q=0.
- States are IDLE, RUN, PAUSE and DONE. Per-edge priority is: reset > abort > start-accept > hold > terminal check > increment.
- IDLE: count=0, busy=0.
  - start=1 latches term_q=term_val and periodic_q=periodic, sets count=0, and moves to RUN.
- RUN:
  - hold=1: go to PAUSE with count unchanged.
  - Else if count==term_q: done=1 for the next cycle only.
    - periodic_q=1: count=0, stay in RUN.
    - periodic_q=0: go to DONE, count holds term_q.
  - Otherwise: count=count+1.
  - start is ignored in RUN and PAUSE. term_val and periodic changes are ignored until the next accepted start.
- PAUSE:
  - count holds, busy=1.
  - hold=0: return to RUN. Counting resumes on the following edge, so no cycle is skipped or double-counted.
  - The terminal check is deferred while paused.
- DONE: count=term_q, busy=0.
  - start=1 restarts exactly as from IDLE.
  - Otherwise the block stays in DONE.
- abort=1 (any state): state IDLE, count=0, done=0 on the next edge. abort together with start in the same cycle also goes to IDLE.
- Timing, start sampled at edge k, hold=0:
  - count = n after edge k+n, for n ≤ T.
  - One-shot: done is high after edge k+T+1, state DONE.
  - Periodic: count cycles 0..T with period T+1. done is high during the count=0 cycle after each T.
- term_val=0:
  - One-shot: count stays 0; done pulses after edge k+1; state DONE.
  - Periodic: done is high every cycle from edge k+1 onward.
- term_val = 2^WIDTH−1: the full range is used. The counter never wraps on its own; wrap happens only via the terminal reload.
- done is never high for more than one cycle in one-shot mode. done is forced low in IDLE and PAUSE.
- Reset mid-run: all outputs return to reset values on that edge.

Optional Feature:
- Macro: COUNTER_SEQ_PERIOD_CNT_EN.
- Defined:
  - Adds output period_cnt[7:0].
  - Increments on every done pulse and saturates at 255.
  - Cleared by reset, by abort, and by an accepted start.
- Undefined: the port and its register do not exist. All other behaviour is identical.

Decomposition:
- Package counter_seq_pkg:
  - typedef enum logic [1:0] ctrl_state_e {IDLE, RUN, PAUSE, DONE}.
  - localparam PERIOD_CNT_W = 8.
- Sub-module up_counter_core:
  - WIDTH-bit synchronous counter with inputs en, clr, clk, rst (active-low sync) and output q.
  - The FSM in counter_seq_ctrl drives en/clr. Terminal compare stays in the controller.

Test Plan:
- Reset hold: rst=0 for 3 cycles with start=1 → count=0, busy=0, done=0 throughout. After release, the first start is accepted.
- One-shot: term_val=5, periodic=0, start pulse → count 0,1,2,3,4,5. done is a single pulse 6 cycles after start. State DONE with count=5 held. busy falls with done.
- Periodic: term_val=3, periodic=1 → count 0,1,2,3,0,1,2,3…; done pulses every 4 cycles; busy stays high. With the macro, period_cnt=3 after three pulses.
- Hold: term_val=9, hold high 4 cycles at count=4 → count stays 4 for those cycles, then continues 5..9. done arrives exactly 4 cycles late.
- Abort and conflicts:
  - abort while count=6 → count=0, IDLE next cycle, no done pulse.
  - start during RUN → ignored.
  - start+abort in the same cycle → IDLE.
- Edge values:
  - term_val=0 one-shot → done pulse one cycle after start.
  - term_val=15 periodic → counts 0..15 with no glitch at reload.
  - Restart from DONE with a new term_val=2 → new value used.
